// File: rtl/fpu_issue_sched_if.sv
// rtl/fpu_issue_sched_if.sv - request, datapath and response signals between core, scheduler and FPU datapath
interface fpu_issue_sched_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_x1;
    logic [31:0] req_x2;
    logic [3:0]  unit_op;
    logic [31:0] unit_x1;
    logic [31:0] unit_x2;
    logic        unit_start;
    logic [31:0] unit_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_op, req_x1, req_x2, unit_result, resp_ready,
        input  req_ready, unit_op, unit_x1, unit_x2, unit_start,
               resp_valid, resp_result, resp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_x1, req_x2, unit_result, resp_ready,
        output req_ready, unit_op, unit_x1, unit_x2, unit_start,
               resp_valid, resp_result, resp_err, busy
    );
endinterface

// File: rtl/fpu_issue_sched.sv
// rtl/fpu_issue_sched.sv - variable-latency FPU issue scheduler; FPU_SCHED_B2B_EN enables DONE->RUN back-to-back issue
module fpu_issue_sched #(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 2,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    fpu_issue_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             req_ready_c;
    logic             accept;
    logic             retire;
    logic             capture;
    logic             unit_illegal;

    // Counter preload is latency minus one so the result is sampled on edge E(L).
    function automatic logic [CNT_W-1:0] lat_m1(input logic [3:0] op);
        logic [CNT_W-1:0] r;
        case (op)
            4'd0, 4'd1: r = CNT_W'(LAT_ADD - 1);
            4'd2:       r = CNT_W'(LAT_MUL - 1);
            4'd3:       r = CNT_W'(LAT_DIV - 1);
            4'd4:       r = CNT_W'(LAT_SQRT - 1);
            default:    r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (cnt == '0) state_nxt = DONE;
            DONE: if (retire) state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = 1'b0;
        case (state)
            IDLE: req_ready_c = 1'b1;
`ifdef FPU_SCHED_B2B_EN
            DONE: req_ready_c = bus.resp_ready;
`else
            DONE: req_ready_c = 1'b0;
`endif
            default: req_ready_c = 1'b0;
        endcase
    end

    // req_ready is gated by rstn so nothing is offered while reset is asserted.
    assign bus.req_ready = rstn & req_ready_c;
    assign accept        = bus.req_ready & bus.req_valid;
    assign retire        = (state == DONE) & bus.resp_ready;
    assign capture       = (state == RUN) & (cnt == '0);
    assign unit_illegal  = (bus.unit_op[3:1] == 3'b111);
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt             <= '0;
            bus.unit_op     <= '0;
            bus.unit_x1     <= '0;
            bus.unit_x2     <= '0;
            bus.unit_start  <= 1'b0;
            bus.resp_valid  <= 1'b0;
            bus.resp_result <= '0;
            bus.resp_err    <= 1'b0;
        end else begin
            bus.unit_start <= accept;
            if (accept) begin
                bus.unit_op <= bus.req_op;
                bus.unit_x1 <= bus.req_x1;
                bus.unit_x2 <= bus.req_x2;
                cnt         <= lat_m1(bus.req_op);
            end else if ((state == RUN) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                bus.resp_valid  <= 1'b1;
                bus.resp_result <= unit_illegal ? 32'd0 : bus.unit_result;
                bus.resp_err    <= unit_illegal;
            end else if (retire) begin
                bus.resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb/tb_fpu_issue_sched.sv - randomized self-checking bench for fpu_issue_sched against a latency/result model
module tb_fpu_issue_sched;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_issue_sched_if bus();

    fpu_issue_sched dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Datapath stand-in: a distinct value per op so a wrong op or operand is visible.
    function automatic logic [31:0] dp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 4'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 4'd13) return a;
        return (a + {b[15:0], b[31:16]}) ^ {8{op}};
    endfunction

    assign bus.unit_result = dp(bus.unit_op, bus.unit_x1, bus.unit_x2);

    function automatic int ref_lat(input logic [3:0] op);
        if (op <= 4'd1) return 2;
        if (op == 4'd2) return 2;
        if (op == 4'd3) return 8;
        if (op == 4'd4) return 8;
        return 1;
    endfunction

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op >= 4'd14) ? 32'd0 : dp(op, a, b);
    endfunction

    // One full transaction; returns observations for the scenario task to judge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int bp, input bit noise,
                         output int lat, output logic [31:0] res, output logic err,
                         output int starts, output bit held, output bit stable,
                         output bit idle_after, output int acc_cyc);
        int n;
        held = 1'b1; stable = 1'b1; starts = 0;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_x1 = a; bus.req_x2 = b;
        @(posedge clk); #1 acc_cyc = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 40) begin
            if (bus.unit_start) starts++;
            if (bus.unit_op !== op || bus.unit_x1 !== a || bus.unit_x2 !== b) held = 1'b0;
            if (noise) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_op = 4'($urandom); bus.req_x1 = $urandom; bus.req_x2 = $urandom;
            end
            @(negedge clk);
            n++;
        end
        lat = bus.resp_valid ? n : -1;
        res = bus.resp_result;
        err = bus.resp_err;
        for (int i = 0; i < bp; i++) begin
            if (bus.unit_start) starts++;
            if (noise) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_op = 4'($urandom); bus.req_x1 = $urandom;
            end
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_result !== res || bus.resp_err !== err || bus.req_ready !== 1'b0)
                stable = 1'b0;
            if (bus.unit_op !== op || bus.unit_x1 !== a || bus.unit_x2 !== b) held = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        if (bus.unit_start) starts++;
        idle_after = !bus.resp_valid && !bus.busy && bus.req_ready;
    endtask

    task automatic test_reset();
        logic [137:0] outs;
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            outs = {bus.req_ready, bus.unit_op, bus.unit_x1, bus.unit_x2, bus.unit_start,
                    bus.resp_valid, bus.resp_result, bus.resp_err, bus.busy};
            tests++;
            if (outs !== '0) begin failed++; $display("FAIL reset_outs: got %h want 0", outs); end
        end
        rstn = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL reset_release: req_ready=%b busy=%b want 1 0", bus.req_ready, bus.busy);
        end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failed++; $display("FAIL reset_idle: busy=%b resp_valid=%b want 0 0", bus.busy, bus.resp_valid);
        end
    endtask

    task automatic test_fadd();
        int lat, st, ac; logic [31:0] r; logic e; bit h, s, ia;
        do_op(4'd0, 32'h3F800000, 32'h40000000, 0, 1'b0, lat, r, e, st, h, s, ia, ac);
        tests++; if (lat != 2) begin failed++; $display("FAIL fadd_lat: got %0d want 2", lat); end
        tests++; if (r !== 32'h40400000) begin failed++; $display("FAIL fadd_res: got %h want 40400000", r); end
        tests++; if (e !== 1'b0) begin failed++; $display("FAIL fadd_err: got %b want 0", e); end
        tests++; if (st != 1) begin failed++; $display("FAIL fadd_start: got %0d want 1", st); end
        tests++; if (!h || !ia) begin failed++; $display("FAIL fadd_hold_idle: got %b%b want 11", h, ia); end
    endtask

    task automatic test_fdiv_backpressure();
        int lat, st, ac; logic [31:0] r, a, b; logic e; bit h, s, ia;
        a = $urandom; b = $urandom;
        do_op(4'd3, a, b, 5, 1'b1, lat, r, e, st, h, s, ia, ac);
        tests++; if (lat != 8) begin failed++; $display("FAIL fdiv_lat: got %0d want 8", lat); end
        tests++; if (r !== ref_res(4'd3, a, b)) begin failed++; $display("FAIL fdiv_res: got %h want %h", r, ref_res(4'd3, a, b)); end
        tests++; if (!s) begin failed++; $display("FAIL fdiv_stable: got 0 want 1"); end
        tests++; if (st != 1 || !h) begin failed++; $display("FAIL fdiv_no_accept: starts=%0d held=%b want 1 1", st, h); end
        tests++; if (!ia) begin failed++; $display("FAIL fdiv_idle: got 0 want 1"); end
    endtask

    task automatic test_single_cycle();
        int lat, st, ac0, ac1; logic [31:0] r, b; logic e; bit h, s, ia;
        b = $urandom;
        do_op(4'd13, 32'hDEADBEEF, b, 0, 1'b0, lat, r, e, st, h, s, ia, ac0);
        tests++; if (lat != 1) begin failed++; $display("FAIL fmv_lat: got %0d want 1", lat); end
        tests++; if (r !== 32'hDEADBEEF) begin failed++; $display("FAIL fmv_res: got %h want deadbeef", r); end
        do_op(4'd10, 32'h12345678, b, 0, 1'b0, lat, r, e, st, h, s, ia, ac1);
        tests++; if (lat != 1) begin failed++; $display("FAIL feq_lat: got %0d want 1", lat); end
        tests++; if (r !== ref_res(4'd10, 32'h12345678, b)) begin failed++; $display("FAIL feq_res: got %h want %h", r, ref_res(4'd10, 32'h12345678, b)); end
        tests++; if (ac1 - ac0 != 3) begin failed++; $display("FAIL issue_spacing: got %0d want 3", ac1 - ac0); end
    endtask

    task automatic test_illegal();
        int lat, st, ac; logic [31:0] r; logic e; bit h, s, ia;
        do_op(4'd15, $urandom, $urandom, 0, 1'b0, lat, r, e, st, h, s, ia, ac);
        tests++; if (lat != 1) begin failed++; $display("FAIL illegal_lat: got %0d want 1", lat); end
        tests++; if (r !== 32'd0 || e !== 1'b1) begin failed++; $display("FAIL illegal_resp: got %h/%b want 0/1", r, e); end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        bus.req_valid = 1'b1; bus.req_op = 4'd4; bus.req_x1 = $urandom; bus.req_x2 = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.busy, bus.resp_valid, bus.unit_start, bus.req_ready, bus.unit_op} !== '0) begin
            failed++; $display("FAIL midreset_outs: busy=%b rv=%b us=%b rr=%b op=%0d want all 0",
                               bus.busy, bus.resp_valid, bus.unit_start, bus.req_ready, bus.unit_op);
        end
        rstn = 1'b1;
        #1;
        tests++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failed++; $display("FAIL midreset_idle: req_ready=%b busy=%b want 1 0", bus.req_ready, bus.busy);
        end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.resp_valid || bus.busy) seen++;
        end
        tests++;
        if (seen != 0) begin failed++; $display("FAIL midreset_noresp: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_random();
        int lat, st, ac; logic [31:0] r, a, b; logic e; bit h, s, ia; logic [3:0] op; int bp;
        for (int k = 0; k < 24; k++) begin
            op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; bp = $urandom_range(0, 3);
            do_op(op, a, b, bp, 1'b1, lat, r, e, st, h, s, ia, ac);
            tests++;
            if (lat != ref_lat(op)) begin failed++; $display("FAIL rand_lat op%0d: got %0d want %0d", op, lat, ref_lat(op)); end
            tests++;
            if (r !== ref_res(op, a, b) || e !== (op >= 4'd14)) begin
                failed++; $display("FAIL rand_res op%0d: got %h/%b want %h/%b", op, r, e, ref_res(op, a, b), op >= 4'd14);
            end
            tests++;
            if (st != 1 || !h || !s || !ia) begin
                failed++; $display("FAIL rand_proto op%0d: starts=%0d held=%b stable=%b idle=%b want 1 1 1 1", op, st, h, s, ia);
            end
        end
    endtask

`ifdef FPU_SCHED_B2B_EN
    task automatic test_back_to_back();
        int n, c0, c1; logic [31:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_op = 4'd2; bus.req_x1 = a1; bus.req_x2 = b1;
        @(posedge clk); #1 c0 = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (bus.resp_result !== ref_res(4'd2, a1, b1)) begin
            failed++; $display("FAIL b2b_res1: got %h want %h", bus.resp_result, ref_res(4'd2, a1, b1));
        end
        bus.req_valid = 1'b1; bus.req_x1 = a2; bus.req_x2 = b2;
        @(posedge clk); #1 c1 = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        tests++;
        if (c1 - c0 != 3) begin failed++; $display("FAIL b2b_spacing: got %0d want 3", c1 - c0); end
        tests++;
        if (bus.resp_valid !== 1'b0 || bus.unit_start !== 1'b1 || bus.unit_x1 !== a2) begin
            failed++; $display("FAIL b2b_reissue: rv=%b us=%b x1=%h want 0 1 %h", bus.resp_valid, bus.unit_start, bus.unit_x1, a2);
        end
        n = 0;
        while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (n != 2 || bus.resp_result !== ref_res(4'd2, a2, b2)) begin
            failed++; $display("FAIL b2b_res2: lat=%0d res=%h want 2 %h", n, bus.resp_result, ref_res(4'd2, a2, b2));
        end
        @(negedge clk);
        bus.resp_ready = 1'b0;
        tests++;
        if (bus.busy !== 1'b0) begin failed++; $display("FAIL b2b_idle: busy=%b want 0", bus.busy); end
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_x1 = '0; bus.req_x2 = '0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_fadd();
        test_fdiv_backpressure();
        test_single_cycle();
        test_illegal();
        test_reset_mid_op();
        test_random();
`ifdef FPU_SCHED_B2B_EN
        test_back_to_back();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
